sync_fifo: RTL and testbench

Parametrised single-clock FIFO for same-domain buffering between the UART frame logic and the ALU/register-file command path, where the dual-clock FIFO's synchronisers cost latency for nothing. It generalises the dual-clock FIFO with a fill-level output, programmable almost-full/almost-empty thresholds, a registered read-data valid strobe and optional sticky overflow/underflow error flags. Depth is a power of two set by `ADDR`.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/sync_fifo_ram.sv | 35 +++
 rtl/sync_fifo.sv | 100 ++++++++++
 tb/tb_sync_fifo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO constants: default geometry and threshold defaults used by both
// the single-clock and dual-clock FIFOs.
package fifo_pkg;

  localparam int FIFO_WIDTH     = 8;
  localparam int FIFO_ADDR      = 3;
  localparam int FIFO_AFULL_TH  = 6;
  localparam int FIFO_AEMPTY_TH = 2;

  // Storage depth for a given address width (always a power of two).
  function automatic int fifo_depth(input int addr);
    return 1 << addr;
  endfunction

  localparam int FIFO_DEPTH = fifo_depth(FIFO_ADDR);

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x WIDTH register array for sync_fifo. The array itself is never
// reset; only the registered read port is, so the read data starts at zero.
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int ADDR  = FIFO_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ADDR-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [ADDR-1:0]  raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the word on an accepted write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port: load on an accepted read, otherwise hold. Reading
  // the old array contents here means a simultaneous write is never forwarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fill level, almost-full/almost-empty thresholds,
// registered read-valid strobe and optional sticky error flags.
// Optional feature: define SYNC_FIFO_STICKY_ERR_EN to build the sticky
// overflow/underflow flags; otherwise they are tied to 0 and err_clr is unused.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int ADDR      = FIFO_ADDR,
  parameter int AFULL_TH  = FIFO_AFULL_TH,
  parameter int AEMPTY_TH = FIFO_AEMPTY_TH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rinc,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ADDR:0]    level,
  input  logic             err_clr,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = fifo_depth(ADDR);

  logic [ADDR:0] wptr;
  logic [ADDR:0] rptr;
  logic          wr_ok;
  logic          rd_ok;

  // Both requests are judged against the flags as they stand at cycle start.
  assign wr_ok = winc && !full;
  assign rd_ok = rinc && !empty;

  // Flags are pure decodes of the level register.
  assign full         = (level == (ADDR+1)'(DEPTH));
  assign empty        = (level == '0);
  assign almost_full  = (level >= (ADDR+1)'(AFULL_TH));
  assign almost_empty = (level <= (ADDR+1)'(AEMPTY_TH));

  // Pointers, level counter and read-valid strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr   <= '0;
      rptr   <= '0;
      level  <= '0;
      rvalid <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + (ADDR+1)'(1);
      if (rd_ok) rptr <= rptr + (ADDR+1)'(1);
      rvalid <= rd_ok;
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + (ADDR+1)'(1);
        2'b01:   level <= level - (ADDR+1)'(1);
        default: level <= level;
      endcase
    end
  end

  sync_fifo_ram #(
    .WIDTH (WIDTH),
    .ADDR  (ADDR)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wptr[ADDR-1:0]),
    .wdata (wdata),
    .re    (rd_ok),
    .raddr (rptr[ADDR-1:0]),
    .rdata (rdata)
  );

`ifdef SYNC_FIFO_STICKY_ERR_EN
  // Sticky error flags; a new error in the clearing cycle takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && full)  overflow  <= 1'b1;
      else if (err_clr)  overflow  <= 1'b0;
      if (rinc && empty) underflow <= 1'b1;
      else if (err_clr)  underflow <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo with default parameters (depth 8).
// Expected read data comes from a scoreboard queue filled as writes are driven.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       winc;
  logic [7:0] wdata;
  logic       rinc;
  logic [7:0] rdata;
  logic       rvalid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] level;
  logic       err_clr;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] sb[$];
  int         m_level = 0;
  logic [7:0] m_rdata = 8'h00;
  logic       m_ovf   = 1'b0;
  logic       m_unf   = 1'b0;

  always #5 clk = ~clk;

  sync_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .winc         (winc),
    .wdata        (wdata),
    .rinc         (rinc),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  function automatic logic exp_ovf();
`ifdef SYNC_FIFO_STICKY_ERR_EN
    return m_ovf;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_unf();
`ifdef SYNC_FIFO_STICKY_ERR_EN
    return m_unf;
`else
    return 1'b0;
`endif
  endfunction

  // Compare every output against the model; 'tag' names the scenario.
  task automatic check_outputs(input string tag, input logic exp_rvalid);
    checks++;
    if (rvalid !== exp_rvalid) begin
      errors++; $display("FAIL %s rvalid: got %b want %b", tag, rvalid, exp_rvalid);
    end
    checks++;
    if (rdata !== m_rdata) begin
      errors++; $display("FAIL %s rdata: got %h want %h", tag, rdata, m_rdata);
    end
    checks++;
    if (level !== 4'(m_level)) begin
      errors++; $display("FAIL %s level: got %0d want %0d", tag, level, m_level);
    end
    checks++;
    if (full !== (m_level == 8) || empty !== (m_level == 0)) begin
      errors++; $display("FAIL %s full/empty: got %b/%b want %b/%b", tag, full, empty,
                         (m_level == 8), (m_level == 0));
    end
    checks++;
    if (almost_full !== (m_level >= 6) || almost_empty !== (m_level <= 2)) begin
      errors++; $display("FAIL %s almost_full/almost_empty: got %b/%b want %b/%b", tag,
                         almost_full, almost_empty, (m_level >= 6), (m_level <= 2));
    end
    checks++;
    if (overflow !== exp_ovf() || underflow !== exp_unf()) begin
      errors++; $display("FAIL %s overflow/underflow: got %b/%b want %b/%b", tag,
                         overflow, underflow, exp_ovf(), exp_unf());
    end
  endtask

  // One clock cycle: drive requests, update the model, check after the edge.
  task automatic cycle(input string tag, input logic w, input logic [7:0] d,
                       input logic r, input logic clr);
    logic wa, ra;
    winc = w; wdata = d; rinc = r; err_clr = clr;
    wa = w && (m_level != 8);
    ra = r && (m_level != 0);
    if (ra) m_rdata = sb.pop_front();
    if (wa) sb.push_back(d);
    if (w && m_level == 8) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (r && m_level == 0) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
    if (wa && !ra) m_level++;
    if (ra && !wa) m_level--;
    @(posedge clk); #1;
    winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
    check_outputs(tag, ra);
  endtask

  task automatic model_reset();
    sb.delete();
    m_level = 0; m_rdata = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic test_reset();
    winc = 1'b1; wdata = 8'h55; rinc = 1'b0; err_clr = 1'b0;
    rst = 1'b0;
    model_reset();
    #3;
    check_outputs("reset_async", 1'b0);
    @(posedge clk); #1;
    check_outputs("reset_held", 1'b0);
    winc = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_outputs("reset_release", 1'b0);
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    cycle("fill_reject", 1'b1, 8'hFF, 1'b0, 1'b0);
    checks++;
    if (level !== 4'd8 || full !== 1'b1) begin
      errors++; $display("FAIL fill_9th level/full: got %0d/%b want 8/1", level, full);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("drain_underflow", 1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (rdata !== 8'h08) begin
      errors++; $display("FAIL drain_hold rdata: got %h want 08", rdata);
    end
  endtask

  task automatic test_err_clr();
    cycle("err_clr", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle("err_refill", 1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    cycle("err_set_wins", 1'b1, 8'hEE, 1'b0, 1'b1);
    cycle("err_clr2", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle("err_drain", 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) cycle("wrap_w5", 1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle("wrap_r5", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle("wrap_w8", 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle("wrap_r8", 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 3; i++) cycle("sim_pre3", 1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle("sim_lvl3", 1'b1, 8'h50 + 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle("sim_fill", 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    cycle("sim_full", 1'b1, 8'h77, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cycle("sim_drain", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("sim_empty", 1'b1, 8'h88, 1'b1, 1'b0);
    cycle("sim_last", 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) cycle("ar_burst", 1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    cycle("ar_ovf_path", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("ar_refill", 1'b1, 8'hC5, 1'b0, 1'b0);
    winc = 1'b1; wdata = 8'hCC; rinc = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_outputs("ar_mid", 1'b0);
    winc = 1'b0; rinc = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    check_outputs("ar_after", 1'b0);
    cycle("ar_write", 1'b1, 8'hD1, 1'b0, 1'b0);
    cycle("ar_read", 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; winc = 1'b0; wdata = 8'h00; rinc = 1'b0; err_clr = 1'b0;
    #2;
    test_reset();
    test_fill();
    test_drain();
    test_err_clr();
    test_wrap();
    test_simultaneous();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
